// File: rtl/heatmap_grid_reader_if.sv
// Bus bundle between the heat-map grid reader, the cell buffer, the grid writer and the VGA framebuffer writer.
// master = the reader, slave = everything around it.
interface heatmap_grid_reader_if;
   logic        done_write_sig;
   logic        comp_allow;
   logic [7:0]  read_addr;
   logic [31:0] read_data;
   // Pixel handshake: a pixel moves on every cycle where vga_valid and vga_ready are both high;
   // once vga_valid is raised, vga_x/vga_y/vga_color stay stable until that transfer happens.
   logic [9:0]  vga_x;
   logic [9:0]  vga_y;
   logic [7:0]  vga_color;
   logic        vga_valid;
   logic        vga_ready;
   logic        frame_done;
   logic        overrun;
   logic [2:0]  state_dbg;

   modport master (
      input  done_write_sig, read_data, vga_ready,
      output comp_allow, read_addr, vga_x, vga_y, vga_color, vga_valid,
             frame_done, overrun, state_dbg
   );

   modport slave (
      output done_write_sig, read_data, vga_ready,
      input  comp_allow, read_addr, vga_x, vga_y, vga_color, vga_valid,
             frame_done, overrun, state_dbg
   );
endinterface

// File: rtl/heatmap_grid_reader.sv
// Reads the 64-cell colour buffer after each fill and paints every cell as a CELL_PX square of VGA pixels.
// Optional cell outline: define HEATMAP_GRID_READER_BORDER_EN.
module heatmap_grid_reader #(
   parameter int          GRID_W       = 8,
   parameter int          GRID_H       = 8,
   parameter int          CELL_PX      = 8,
   parameter logic [9:0]  X0           = 10'd64,
   parameter logic [9:0]  Y0           = 10'd48,
   parameter int          REARM_CYC    = 2,
   parameter logic [7:0]  BORDER_COLOR = 8'h00
) (
   input  logic                  clk_50,
   input  logic                  reset,
   heatmap_grid_reader_if.master bus
);
   localparam int CELLS  = GRID_W * GRID_H;
   localparam int CELL_W = $clog2(CELLS);
   localparam int COL_W  = $clog2(GRID_W);
   localparam int ROW_W  = $clog2(GRID_H);
   localparam int PX_W   = $clog2(CELL_PX);
   localparam int RC_W   = $clog2(REARM_CYC + 1);

   localparam logic [PX_W-1:0]   PX_MAX   = PX_W'(CELL_PX - 1);
   localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(GRID_W - 1);
   localparam logic [CELL_W-1:0] CELL_MAX = CELL_W'(CELLS - 1);
   localparam logic [RC_W-1:0]   RC_LAST  = RC_W'(REARM_CYC - 1);

   typedef enum logic [2:0] {
      WAIT_FILL = 3'd0,
      RD_ADDR   = 3'd1,
      RD_WAIT   = 3'd2,
      DRAW      = 3'd3,
      REARM     = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [CELL_W-1:0] cell_q, cell_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [PX_W-1:0]   px_x_q, px_x_d, px_y_q, px_y_d;
   logic [RC_W-1:0]   rearm_cnt_q, rearm_cnt_d;
   logic [7:0]        colour_q, colour_d;
   logic              comp_allow_q, comp_allow_d;
   logic [7:0]        read_addr_q, read_addr_d;
   logic [9:0]        vga_x_q, vga_x_d, vga_y_q, vga_y_d;
   logic [7:0]        vga_color_q, vga_color_d;
   logic              vga_valid_q, vga_valid_d;
   logic              frame_done_q, frame_done_d;
   logic              overrun_q, overrun_d;
   logic              last_px;
   logic [9:0]        pix_x, pix_y;
   logic [7:0]        pix_c;
   logic              unused_bits;

   always_comb begin
      state_d      = state_q;
      cell_d       = cell_q;
      col_d        = col_q;
      row_d        = row_q;
      px_x_d       = px_x_q;
      px_y_d       = px_y_q;
      rearm_cnt_d  = rearm_cnt_q;
      colour_d     = colour_q;
      comp_allow_d = comp_allow_q;
      read_addr_d  = read_addr_q;
      vga_valid_d  = vga_valid_q;
      frame_done_d = 1'b0;
      overrun_d    = overrun_q | (bus.done_write_sig && (state_q != WAIT_FILL));
      last_px      = (px_x_q == PX_MAX) && (px_y_q == PX_MAX);

      unique case (state_q)
         WAIT_FILL: begin
            if (bus.done_write_sig) begin
               state_d     = RD_ADDR;
               cell_d      = '0;
               col_d       = '0;
               row_d       = '0;
               px_x_d      = '0;
               px_y_d      = '0;
               read_addr_d = '0;
            end
         end
         RD_ADDR: state_d = RD_WAIT;
         RD_WAIT: begin
            colour_d    = bus.read_data[7:0];
            vga_valid_d = 1'b1;
            state_d     = DRAW;
         end
         DRAW: begin
            if (bus.vga_ready) begin
               if (last_px) begin
                  vga_valid_d = 1'b0;
                  px_x_d      = '0;
                  px_y_d      = '0;
                  if (cell_q == CELL_MAX) begin
                     frame_done_d = 1'b1;
                     comp_allow_d = 1'b1;
                     rearm_cnt_d  = '0;
                     state_d      = REARM;
                  end else begin
                     cell_d      = cell_q + 1'b1;
                     read_addr_d = 8'(cell_q + 1'b1);
                     if (col_q == COL_MAX) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                     end else begin
                        col_d = col_q + 1'b1;
                     end
                     state_d = RD_ADDR;
                  end
               end else if (px_x_q == PX_MAX) begin
                  px_x_d = '0;
                  px_y_d = px_y_q + 1'b1;
               end else begin
                  px_x_d = px_x_q + 1'b1;
               end
            end
         end
         REARM: begin
            if (rearm_cnt_q == RC_LAST) begin
               comp_allow_d = 1'b0;
               state_d      = WAIT_FILL;
               rearm_cnt_d  = '0;
               cell_d       = '0;
               col_d        = '0;
               row_d        = '0;
               px_x_d       = '0;
               px_y_d       = '0;
            end else begin
               rearm_cnt_d = rearm_cnt_q + 1'b1;
            end
         end
         default: state_d = WAIT_FILL;
      endcase

      // Pixel outputs follow the next-cycle counters; a stall leaves the counters, and so the pixel, unchanged.
      pix_x = X0 + (10'(col_d) << PX_W) + 10'(px_x_d);
      pix_y = Y0 + (10'(row_d) << PX_W) + 10'(px_y_d);
`ifdef HEATMAP_GRID_READER_BORDER_EN
      pix_c = ((px_x_d == PX_MAX) || (px_y_d == PX_MAX)) ? BORDER_COLOR : colour_d;
`else
      pix_c = colour_d;
`endif
      vga_x_d     = vga_x_q;
      vga_y_d     = vga_y_q;
      vga_color_d = vga_color_q;
      if (vga_valid_d) begin
         vga_x_d     = pix_x;
         vga_y_d     = pix_y;
         vga_color_d = pix_c;
      end
   end

   always_ff @(posedge clk_50 or negedge reset) begin
      if (!reset) begin
         state_q      <= WAIT_FILL;
         cell_q       <= '0;
         col_q        <= '0;
         row_q        <= '0;
         px_x_q       <= '0;
         px_y_q       <= '0;
         rearm_cnt_q  <= '0;
         colour_q     <= '0;
         comp_allow_q <= 1'b0;
         read_addr_q  <= '0;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_color_q  <= '0;
         vga_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cell_q       <= cell_d;
         col_q        <= col_d;
         row_q        <= row_d;
         px_x_q       <= px_x_d;
         px_y_q       <= px_y_d;
         rearm_cnt_q  <= rearm_cnt_d;
         colour_q     <= colour_d;
         comp_allow_q <= comp_allow_d;
         read_addr_q  <= read_addr_d;
         vga_x_q      <= vga_x_d;
         vga_y_q      <= vga_y_d;
         vga_color_q  <= vga_color_d;
         vga_valid_q  <= vga_valid_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
      end
   end

   assign bus.comp_allow = comp_allow_q;
   assign bus.read_addr  = read_addr_q;
   assign bus.vga_x      = vga_x_q;
   assign bus.vga_y      = vga_y_q;
   assign bus.vga_color  = vga_color_q;
   assign bus.vga_valid  = vga_valid_q;
   assign bus.frame_done = frame_done_q;
   assign bus.overrun    = overrun_q;
   assign bus.state_dbg  = state_q;

`ifdef HEATMAP_GRID_READER_BORDER_EN
   assign unused_bits = ^bus.read_data[31:8];
`else
   assign unused_bits = ^{bus.read_data[31:8], BORDER_COLOR};
`endif
endmodule
